// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared size codes, FSM state encodings and helpers for the
//                load/store unit.
//  Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

    // Access size codes as presented on req_size (2'b11 behaves as a word)
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Control FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_WRITE  = 2'b10;
    localparam logic [1:0] ST_RESP   = 2'b11;

    // Both SIZE_WORD and the reserved code 2'b11 are full-word accesses
    function automatic logic size_is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_if
//  Description : CPU request/response and RAM bus signals of the load/store
//                unit. The unit uses the slave modport; the environment
//                (CPU plus RAM) uses the master modport.
//  Revision    : 1.0  initial release
// ============================================================================
interface load_store_unit_if #(
    parameter int N = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [N-1:0]  req_addr;
    logic [N-1:0]  req_wdata;
    logic          resp_valid;
    logic [N-1:0]  resp_rdata;
    logic [N-1:0]  mem_addr;
    logic [N-1:0]  mem_write_data;
    logic          mem_write_enable;
    logic [N-1:0]  mem_data;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_data,
        output req_ready, resp_valid, resp_rdata,
        output mem_addr, mem_write_data, mem_write_enable
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_data,
        input  req_ready, resp_valid, resp_rdata,
        input  mem_addr, mem_write_data, mem_write_enable
    );
endinterface
`default_nettype wire

// File: rtl/byte_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : byte_lane_align
//  Description : Combinational lane logic. Sign/zero-extends the low byte or
//                half of a RAM word for loads, and merges sub-word store data
//                into the low lanes of a previously read word.
//  Revision    : 1.0  initial release
// ============================================================================
module byte_lane_align
    import lsu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [1:0]   size,
    input  logic         zero_ext,
    input  logic [N-1:0] raw_word,
    input  logic [N-1:0] old_word,
    input  logic [N-1:0] store_data,
    output logic [N-1:0] load_word,
    output logic [N-1:0] store_word
);

    logic w_byte_fill;
    logic w_half_fill;

    assign w_byte_fill = ~zero_ext & raw_word[7];
    assign w_half_fill = ~zero_ext & raw_word[15];

    // Select extension and merge by access size; word sizes pass straight through
    always_comb begin
        load_word  = raw_word;
        store_word = store_data;
        case (size)
            SIZE_BYTE: begin
                load_word  = {{(N-8){w_byte_fill}}, raw_word[7:0]};
                store_word = {old_word[N-1:8], store_data[7:0]};
            end
            SIZE_HALF: begin
                load_word  = {{(N-16){w_half_fill}}, raw_word[15:0]};
                store_word = {old_word[N-1:16], store_data[15:0]};
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Turns CPU byte/half/word load-store requests into accesses
//                on a combinational-read, full-word-write RAM. Sub-word
//                stores are done as read-modify-write. One request is in
//                flight at a time.
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);

    logic [1:0]   r_state;
    logic [N-1:0] r_addr;
    logic [1:0]   r_size;
    logic         r_zero_ext;
    logic         r_write;
    logic [N-1:0] r_wdata;
    logic [N-1:0] r_old_word;
    logic [N-1:0] r_rdata;

    logic         w_is_word;
    logic         w_we;
    logic [N-1:0] w_load_word;
    logic [N-1:0] w_store_word;

    assign w_is_word = size_is_word(r_size);

    byte_lane_align #(
        .N (N)
    ) u_align (
        .size       (r_size),
        .zero_ext   (r_zero_ext),
        .raw_word   (bus.mem_data),
        .old_word   (r_old_word),
        .store_data (r_wdata),
        .load_word  (w_load_word),
        .store_word (w_store_word)
    );

    // Sequence one request: latch in IDLE, read/write in ACCESS, merge-write in WRITE, respond in RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_size     <= '0;
            r_zero_ext <= 1'b0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_old_word <= '0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_addr     <= bus.req_addr;
                        r_size     <= bus.req_size;
                        r_zero_ext <= bus.req_unsigned;
                        r_write    <= bus.req_write;
                        r_wdata    <= bus.req_wdata;
                        r_state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!r_write) begin
                        r_rdata <= w_load_word;
                        r_state <= ST_RESP;
                    end else if (w_is_word) begin
                        // Full word was written directly at this edge
                        r_rdata <= '0;
                        r_state <= ST_RESP;
                    end else begin
                        // Keep the current word so its untouched lanes survive the write
                        r_old_word <= bus.mem_data;
                        r_rdata    <= '0;
                        r_state    <= ST_WRITE;
                    end
                end
                ST_WRITE: r_state <= ST_RESP;
                ST_RESP:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // RAM strobe is suppressed during reset so an interrupted store never commits
    always_comb begin
        w_we = 1'b0;
        if (!rst) begin
            if (r_state == ST_WRITE) begin
                w_we = 1'b1;
            end else if ((r_state == ST_ACCESS) && r_write && w_is_word) begin
                w_we = 1'b1;
            end
        end
    end

    assign bus.req_ready        = (r_state == ST_IDLE);
    assign bus.resp_valid       = (r_state == ST_RESP);
    assign bus.resp_rdata       = (r_state == ST_RESP) ? r_rdata : '0;
    assign bus.mem_addr         = r_addr;
    assign bus.mem_write_enable = w_we;
    assign bus.mem_write_data   = w_we ? w_store_word : '0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Bench for load_store_unit with a 1 KiB byte RAM, a
//                byte-level shadow memory model and directed requests.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    localparam int RAM_SIZE = 1024;

    logic clk;
    logic rst;

    load_store_unit_if #(.N(32)) bus ();

    load_store_unit #(.N(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- RAM: combinational read, full-word write ------------
    logic [7:0] ram [RAM_SIZE];
    logic [9:0] ra;
    assign ra = bus.mem_addr[9:0];
    assign bus.mem_data = {ram[ra + 10'd3], ram[ra + 10'd2], ram[ra + 10'd1], ram[ra]};

    initial begin
        for (int i = 0; i < RAM_SIZE; i++) ram[i] = 8'hAA;
        forever begin
            @(posedge clk);
            if (bus.mem_write_enable)
                for (int i = 0; i < 4; i++) ram[ra + 10'(i)] <= bus.mem_write_data[8*i +: 8];
        end
    end

    // ---------------- checking bookkeeping ---------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model: byte shadow memory ---------------
    logic [7:0] sh [RAM_SIZE];

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] sh_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sh[a[9:0] + 10'(i)];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
        logic [31:0] w;
        w = sh_word(a);
        case (sz)
            2'b00:   return u ? {24'h0, w[7:0]}  : 32'($signed(w[7:0]));
            2'b01:   return u ? {16'h0, w[15:0]} : 32'($signed(w[15:0]));
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_store_word(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w;
        w = sh_word(a);
        for (int i = 0; i < nbytes(sz); i++) w[8*i +: 8] = d[8*i +: 8];
        return w;
    endfunction

    task automatic model_apply(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        for (int i = 0; i < nbytes(sz); i++) sh[a[9:0] + 10'(i)] = d[8*i +: 8];
    endtask

    // ---------------- compare process (every cycle, at negedge) -----------
    logic        pend;
    logic        pend_write;
    logic [1:0]  pend_size;
    logic [31:0] pend_addr;
    logic [31:0] pend_wdata;
    logic [31:0] pend_data;
    int          pend_cyc;
    int          acc_cyc;
    int          we_cnt;
    int          cyc;
    logic [31:0] got_q [$];
    int          lat_q [$];

    initial begin
        for (int i = 0; i < RAM_SIZE; i++) sh[i] = 8'hAA;
        pend = 1'b0; pend_cyc = 0; acc_cyc = 0; we_cnt = 0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("we_during_reset", 32'(bus.mem_write_enable), 32'h0);
                pend = 1'b0;
            end else begin
                chk("req_ready", 32'(bus.req_ready), 32'(!pend));
                if (pend && cyc == pend_cyc) begin
                    chk("resp_valid", 32'(bus.resp_valid), 32'h1);
                    chk("resp_rdata", bus.resp_rdata, pend_data);
                    chk("we_cycles", 32'(we_cnt), pend_write ? 32'h1 : 32'h0);
                    if (pend_write) model_apply(pend_addr, pend_size, pend_wdata);
                    got_q.push_back(bus.resp_rdata);
                    lat_q.push_back(cyc - acc_cyc);
                    pend = 1'b0;
                end else begin
                    chk("resp_valid_idle", 32'(bus.resp_valid), 32'h0);
                end
                if (bus.mem_write_enable) begin
                    we_cnt++;
                    chk("we_allowed", 32'(pend && pend_write), 32'h1);
                    chk("mem_addr", bus.mem_addr, pend_addr);
                    chk("mem_write_data", bus.mem_write_data,
                        model_store_word(pend_addr, pend_size, pend_wdata));
                end else begin
                    chk("mem_write_data_idle", bus.mem_write_data, 32'h0);
                end
                if (bus.req_valid && bus.req_ready) begin
                    pend       = 1'b1;
                    acc_cyc    = cyc;
                    pend_write = bus.req_write;
                    pend_size  = bus.req_size;
                    pend_addr  = bus.req_addr;
                    pend_wdata = bus.req_wdata;
                    pend_data  = bus.req_write ? 32'h0 : model_load(bus.req_addr, bus.req_size, bus.req_unsigned);
                    pend_cyc   = cyc + ((bus.req_write && nbytes(bus.req_size) < 4) ? 3 : 2);
                    we_cnt     = 0;
                end
            end
        end
    end

    // ---------------- driver tasks -----------------------------------------
    // Entered and left at posedge+1; keep leaves req_valid high for back-to-back
    task automatic send(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d, input logic keep);
        int guard;
        guard = 0;
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = d;
        while (1) begin
            @(negedge clk);
            if (bus.req_ready) break;
            guard++;
            if (guard > 50) begin
                n_checks++; n_errors++;
                $display("FAIL accept_timeout: req_ready never high for addr 0x%08h", a);
                break;
            end
        end
        @(posedge clk); #1;
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic expect_resp(input string name, input logic [31:0] exp, input int exp_lat);
        int guard;
        guard = 0;
        while (got_q.size() == 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (got_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL %s: no response, expected 0x%08h", name, exp);
        end else begin
            chk(name, got_q.pop_front(), exp);
            if (exp_lat > 0) chk({name, "_latency"}, 32'(lat_q.pop_front()), 32'(exp_lat));
            else void'(lat_q.pop_front());
        end
        @(posedge clk); #1;
    endtask

    // ---------------- directed stimulus -----------------------------------
    initial begin
        int mism;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_req_ready",  32'(bus.req_ready), 32'h1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_mem_addr",   bus.mem_addr, 32'h0);
        chk("rst_mem_we",     32'(bus.mem_write_enable), 32'h0);
        @(posedge clk); #1;

        // Byte loads with sign and zero extension
        send(0, 2'b00, 0, 32'h005, 32'h0, 0); expect_resp("ld_b_s_005", 32'hFFFFFFAA, 2);
        send(0, 2'b00, 1, 32'h005, 32'h0, 0); expect_resp("ld_b_u_005", 32'h000000AA, 2);

        // Byte store (upper wdata bytes must be ignored) then word read-back
        send(1, 2'b00, 0, 32'h004, 32'hCDCDCD12, 0); expect_resp("st_b_004", 32'h0, 3);
        send(0, 2'b10, 0, 32'h004, 32'h0, 0);        expect_resp("ld_w_004_a", 32'hAAAAAA12, 2);

        // Half store and loads
        send(1, 2'b01, 0, 32'h006, 32'h5555BEEF, 0); expect_resp("st_h_006", 32'h0, 3);
        send(0, 2'b10, 0, 32'h004, 32'h0, 0);        expect_resp("ld_w_004_b", 32'hBEEFAA12, 2);
        send(0, 2'b01, 0, 32'h006, 32'h0, 0);        expect_resp("ld_h_s_006", 32'hFFFFBEEF, 2);
        send(0, 2'b01, 1, 32'h006, 32'h0, 0);        expect_resp("ld_h_u_006", 32'h0000BEEF, 2);

        // Word store across the top of the RAM
        send(1, 2'b10, 0, 32'h3FE, 32'h11223344, 0); expect_resp("st_w_3fe", 32'h0, 2);
        send(0, 2'b10, 0, 32'h000, 32'h0, 0);        expect_resp("ld_w_000", 32'hAAAA1122, 2);
        send(0, 2'b10, 0, 32'h3FC, 32'h0, 0);        expect_resp("ld_w_3fc", 32'h3344AAAA, 2);

        // Back-to-back with req_valid held high
        send(1, 2'b00, 0, 32'h020, 32'hFFFFFF7F, 1);
        send(0, 2'b00, 0, 32'h020, 32'h0, 1);
        send(1, 2'b01, 0, 32'h022, 32'h00008001, 1);
        send(0, 2'b01, 0, 32'h022, 32'h0, 1);
        send(0, 2'b10, 0, 32'h020, 32'h0, 1);
        send(0, 2'b11, 1, 32'h020, 32'h0, 0);
        expect_resp("b2b_st_b",   32'h0,        3);
        expect_resp("b2b_ld_b",   32'h0000007F, 2);
        expect_resp("b2b_st_h",   32'h0,        3);
        expect_resp("b2b_ld_h",   32'hFFFF8001, 2);
        expect_resp("b2b_ld_w",   32'h8001AA7F, 2);
        expect_resp("b2b_ld_w11", 32'h8001AA7F, 2);
        repeat (4) @(posedge clk); #1;
        chk("b2b_no_extra_resp", 32'(got_q.size()), 32'h0);

        // Reset while a byte store sits in WRITE
        send(1, 2'b00, 0, 32'h010, 32'h00000055, 0);   // now in ACCESS
        @(posedge clk); #1 rst = 1'b1;                 // WRITE cycle
        @(negedge clk);
        chk("abort_we", 32'(bus.mem_write_enable), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(bus.req_ready), 32'h1);
        chk("abort_resp",  32'(bus.resp_valid), 32'h0);
        chk("abort_ram_word", {ram[10'h013], ram[10'h012], ram[10'h011], ram[10'h010]}, 32'hAAAAAAAA);
        @(posedge clk); #1;
        send(0, 2'b10, 0, 32'h010, 32'h0, 0); expect_resp("ld_w_010", 32'hAAAAAAAA, 2);

        // Whole RAM against the shadow model
        repeat (2) @(posedge clk); #1;
        mism = 0;
        for (int i = 0; i < RAM_SIZE; i++) if (ram[i] !== sh[i]) mism++;
        chk("ram_vs_model_mismatches", 32'(mism), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
